// File: rtl/mig_tt_checker_if.sv
// Bus bundle for the majority-gate truth-table checker.
// start is a one-cycle request taken only while busy is low; done pulses one cycle and tt_out/match/err hold until the next taken start.
interface mig_tt_checker_if;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [14:0] cfg_data;
    logic [3:0]  num_gates;
    logic [3:0]  out_sel;
    logic        out_inv;
    logic [15:0] target_tt;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] tt_out;
    logic        match;
    logic        err;

    modport master (
        output cfg_we, cfg_addr, cfg_data, num_gates, out_sel, out_inv, target_tt, start,
        input  busy, done, tt_out, match, err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, num_gates, out_sel, out_inv, target_tt, start,
        output busy, done, tt_out, match, err
    );
endinterface

// File: rtl/mig_tt_checker.sv
// Evaluates a programmed chain of up to eight 3-input majority gates over all 16 minterms
// and compares the selected output word against a target truth table.
module mig_tt_checker (
    input  logic                   clk,
    input  logic                   rst,
    mig_tt_checker_if.slave        bus,
    output logic [1:0]             o_dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, FINISH = 2'd2} state_t;

    state_t      r_state, w_next_state;
    logic [14:0] r_desc [8];
    logic [15:0] r_res  [8];
    logic [2:0]  r_g;
    logic [3:0]  r_num, r_out_sel;
    logic        r_out_inv, r_err_run, r_match, r_err;
    logic [15:0] r_target, r_tt_out;

    logic [14:0] w_desc;
    logic [15:0] w_op_a, w_op_b, w_op_c, w_gate, w_out_word;
    logic        w_num_bad, w_gate_bad, w_out_bad, w_final_err, w_final_match;

    function automatic logic [15:0] base_word(input logic [3:0] sel, input logic [15:0] slot_val);
        logic [15:0] word;
        case (sel)
            4'd0:    word = 16'h0000;
            4'd1:    word = 16'hAAAA;
            4'd2:    word = 16'hCCCC;
            4'd3:    word = 16'hF0F0;
            4'd4:    word = 16'hFF00;
            default: word = (sel <= 4'd12) ? slot_val : 16'h0000;
        endcase
        return word;
    endfunction

    // A slot reference is only legal if that slot was already computed in this run.
    function automatic logic bad_ref(input logic [3:0] sel, input logic [3:0] limit);
        return (sel >= 4'd13) || ((sel >= 4'd5) && ((sel - 4'd5) >= limit));
    endfunction

    assign w_desc     = r_desc[r_g];
    assign w_op_a     = base_word(w_desc[13:10], r_res[3'(w_desc[13:10] - 4'd5)]) ^ {16{w_desc[14]}};
    assign w_op_b     = base_word(w_desc[8:5],   r_res[3'(w_desc[8:5]   - 4'd5)]) ^ {16{w_desc[9]}};
    assign w_op_c     = base_word(w_desc[3:0],   r_res[3'(w_desc[3:0]   - 4'd5)]) ^ {16{w_desc[4]}};
    assign w_gate     = (w_op_a & w_op_b) | (w_op_a & w_op_c) | (w_op_b & w_op_c);
    assign w_gate_bad = bad_ref(w_desc[13:10], {1'b0, r_g}) | bad_ref(w_desc[8:5], {1'b0, r_g})
                      | bad_ref(w_desc[3:0], {1'b0, r_g});
    assign w_num_bad  = (bus.num_gates == 4'd0) || (bus.num_gates > 4'd8);

    assign w_out_word    = base_word(r_out_sel, r_res[3'(r_out_sel - 4'd5)]) ^ {16{r_out_inv}};
    assign w_out_bad     = bad_ref(r_out_sel, r_num);
    assign w_final_err   = r_err_run | w_out_bad;
    assign w_final_match = (w_out_word == r_target) && !w_final_err;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next_state = w_num_bad ? FINISH : EVAL;
            EVAL:    if ({1'b0, r_g} == (r_num - 4'd1)) w_next_state = FINISH;
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Result outputs show the fresh value during FINISH and the held copy afterwards.
    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == FINISH);
    assign bus.tt_out  = (r_state == FINISH) ? w_out_word    : r_tt_out;
    assign bus.match   = (r_state == FINISH) ? w_final_match : r_match;
    assign bus.err     = (r_state == FINISH) ? w_final_err   : r_err;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_g       <= 3'd0;
            r_num     <= 4'd0;
            r_out_sel <= 4'd0;
            r_out_inv <= 1'b0;
            r_target  <= 16'h0000;
            r_err_run <= 1'b0;
            r_tt_out  <= 16'h0000;
            r_match   <= 1'b0;
            r_err     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_desc[i] <= 15'h0000;
                r_res[i]  <= 16'h0000;
            end
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (bus.cfg_we) r_desc[bus.cfg_addr] <= bus.cfg_data;
                    if (bus.start) begin
                        r_num     <= bus.num_gates;
                        r_out_sel <= bus.out_sel;
                        r_out_inv <= bus.out_inv;
                        r_target  <= bus.target_tt;
                        r_g       <= 3'd0;
                        r_err_run <= w_num_bad;
                    end
                end
                EVAL: begin
                    r_res[r_g] <= w_gate;
                    r_g        <= r_g + 3'd1;
                    if (w_gate_bad) r_err_run <= 1'b1;
                end
                FINISH: begin
                    r_tt_out <= w_out_word;
                    r_match  <= w_final_match;
                    r_err    <= w_final_err;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mig_tt_checker.md
MIG_TT_CHECKER -- requirements
Module: mig_tt_checker

Interface
REQ-001 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 Port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-003 Port cfg_we  input  1  gate-descriptor write strobe.
REQ-004 Port cfg_addr  input  3  gate slot index, 0..7.
REQ-005 Port cfg_data  input  15  gate descriptor: [14:10] operand A, [9:5] operand B, [4:0] operand C; each operand is {inv[4], sel[3:0]}.
REQ-006 Port num_gates  input  4  number of gates to evaluate; valid range 1..8; sampled at start.
REQ-007 Port out_sel  input  4  output operand select, same encoding as sel; sampled at start.
REQ-008 Port out_inv  input  1  output complement; sampled at start.
REQ-009 Port target_tt  input  16  expected truth table; sampled at start.
REQ-010 Port start  input  1  evaluation request, single-cycle pulse.
REQ-011 Port busy  output  1  high while evaluation is in progress.
REQ-012 Port done  output  1  one-cycle completion pulse.
REQ-013 Port tt_out  output  16  computed truth table; held until the next accepted start.
REQ-014 Port match  output  1  tt_out equals sampled target_tt; held with tt_out.
REQ-015 Port err  output  1  illegal program detected; held with tt_out.

Function
REQ-016 Operand sel encoding SHALL be: 0 = constant 0; 1..4 = x0..x3; 5..12 = result of gate slot 0..7; 13..15 = illegal.
REQ-017 Input words SHALL be bit-parallel over all 16 minterms: x0=16'hAAAA, x1=16'hCCCC, x2=16'hF0F0, x3=16'hFF00.
REQ-018 The operand value SHALL be the selected word, bitwise complemented when inv=1.
REQ-019 Each gate SHALL compute the bitwise majority (A&B)|(A&C)|(B&C) of its three operand words.
REQ-020 The FSM SHALL have states IDLE, EVAL, FINISH.
REQ-021 In IDLE, a start pulse SHALL be accepted: num_gates, out_sel, out_inv, and target_tt are latched; the gate counter g is cleared; busy is set.
REQ-022 In IDLE, if num_gates is 0 or greater than 8, start SHALL go directly to FINISH with err=1.
REQ-023 In EVAL, exactly one gate SHALL be evaluated per cycle: slot g's result is written to the result register for g, and g increments.
REQ-024 Evaluation SHALL stop after slot num_gates-1, and the FSM SHALL then go to FINISH.
REQ-025 An operand referencing gate slot k with k >= g (forward or self reference) or with an illegal sel SHALL set a sticky error for the current run; evaluation SHALL still run to completion.
REQ-026 In FINISH, tt_out SHALL take the out_sel operand, complemented if out_inv=1.
REQ-027 In FINISH, an out_sel that references a gate slot >= num_gates, or an illegal out_sel, SHALL set err.
REQ-028 In FINISH, match SHALL be set to (tt_out==target_tt) && !err; done SHALL pulse; busy SHALL clear; the FSM SHALL return to IDLE.
REQ-029 Latency SHALL be: start accepted in cycle 0, done high in cycle num_gates+1 (cycle 1 for an illegal num_gates).
REQ-030 start SHALL be ignored while busy=1; no queuing.
REQ-031 cfg_we SHALL be ignored while busy=1; when idle it writes cfg_data to slot cfg_addr in the same edge.
REQ-032 When start and cfg_we are both asserted in IDLE, the write SHALL take effect first, so the new descriptor is used by the run.
REQ-033 tt_out, match, and err SHALL change only in FINISH; done SHALL never be high for more than one cycle.

Reset
REQ-034 Asserting rst SHALL immediately force: state IDLE; busy=0; done=0; tt_out=16'h0000; match=0; err=0; g=0; all gate descriptors and result registers = 0.
REQ-035 Reset mid-EVAL SHALL abort the run with no done pulse.
REQ-036 After rst deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-037 Scenario: slot0 = maj(x0,x1,x2), num_gates=1, out_sel=5, target=16'hE8E8, start -> done at cycle 2, tt_out=16'hE8E8, match=1, err=0.
REQ-038 Scenario: slot0 = maj(x0,x1,0) and slot1 = maj(x0,x1,~0); run with out_sel=5 -> tt_out=16'h8888; second run with out_sel=6 and out_inv=1 -> tt_out=16'h1111.
REQ-039 Scenario: slot0 operand A sel=6 (forward reference), num_gates=2 -> done at cycle 3, err=1, match=0.
REQ-040 Scenario: num_gates=0 or num_gates=9 -> done at cycle 1, err=1, busy high for exactly one cycle.
REQ-041 Scenario: start and cfg_we pulsed during EVAL of an 8-gate run -> both ignored, done at cycle 9, result unchanged versus an undisturbed run.
REQ-042 Scenario: rst asserted in EVAL cycle 3 -> busy=0 and tt_out=0 immediately, no done pulse; a rerun after reset (descriptors reloaded) gives the correct result.
